// File: rtl/uart_byte_receiver.sv
// uart_byte_receiver: 8N1 UART receiver for the host-side RX pin of the bridge.
// The line is synchronised by two flops, and a START falling edge is detected.
// Each bit is sampled three times around its centre and decided by 2-of-3 majority.
// A received byte is handed to the frame parser over a valid/ready handshake.
module uart_byte_receiver #(
    parameter int CLK_FREQ_HZ     = 125_000_000,
    parameter int BAUD_RATE       = 115200,
    parameter int BIT_TIME_CYCLES = CLK_FREQ_HZ / BAUD_RATE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_error,
    output logic       overrun_error,
    output logic       rx_busy
);

    localparam int MID = BIT_TIME_CYCLES / 2;
    localparam int CW  = $clog2(BIT_TIME_CYCLES);

    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(BIT_TIME_CYCLES - 1);
    localparam logic [CW-1:0] CNT_S0   = CW'(MID - 1);
    localparam logic [CW-1:0] CNT_S1   = CW'(MID);
    localparam logic [CW-1:0] CNT_DEC  = CW'(MID + 1);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
    localparam logic [2:0] ST_STOP      = 3'd3;
    localparam logic [2:0] ST_WAIT_IDLE = 3'd4;

    // 2-of-3 vote across the three samples taken around the bit centre.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    logic          rx_meta_r;
    logic          rx_sync_r;
    logic          rx_prev_r;
    logic [2:0]    state_r;
    logic [2:0]    state_nx_s;
    logic [CW-1:0] bit_cnt_r;
    logic [CW-1:0] bit_cnt_nx_s;
    logic [2:0]    bit_idx_r;
    logic [2:0]    bit_idx_nx_s;
    logic [7:0]    shreg_r;
    logic [7:0]    shreg_nx_s;
    logic          samp0_r;
    logic          samp1_r;
    logic          dec_s;
    logic          last_s;
    logic          maj_s;
    logic          byte_done_s;
    logic          frame_err_s;
    logic [7:0]    rx_data_r;
    logic          rx_valid_r;
    logic          frame_error_r;
    logic          overrun_error_r;
    logic          rx_busy_r;

    assign dec_s  = (bit_cnt_r == CNT_DEC);
    assign last_s = (bit_cnt_r == CNT_LAST);
    assign maj_s  = maj3(samp0_r, samp1_r, rx_sync_r);

    assign rx_data       = rx_data_r;
    assign rx_valid      = rx_valid_r;
    assign frame_error   = frame_error_r;
    assign overrun_error = overrun_error_r;
    assign rx_busy       = rx_busy_r;

    // Two-flop synchroniser plus a delayed copy for falling-edge detection; idles high.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            rx_meta_r <= uart_rx;
            rx_sync_r <= rx_meta_r;
            rx_prev_r <= rx_sync_r;
        end
    end

    // Frame sequencing: next state, bit timing, data shifting and completion events.
    always_comb begin
        state_nx_s   = state_r;
        bit_cnt_nx_s = bit_cnt_r;
        bit_idx_nx_s = bit_idx_r;
        shreg_nx_s   = shreg_r;
        byte_done_s  = 1'b0;
        frame_err_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!rx_sync_r && rx_prev_r) begin
                    state_nx_s   = ST_START;
                    bit_cnt_nx_s = '0;
                end else begin
                    state_nx_s   = ST_IDLE;
                end
            end
            ST_START: begin
                if (dec_s && maj_s) begin
                    // Line back high at mid-START: a glitch, not a frame.
                    state_nx_s   = ST_IDLE;
                    bit_cnt_nx_s = '0;
                end else if (last_s) begin
                    state_nx_s   = ST_DATA;
                    bit_cnt_nx_s = '0;
                    bit_idx_nx_s = 3'd0;
                end else begin
                    bit_cnt_nx_s = bit_cnt_r + CNT_ONE;
                end
            end
            ST_DATA: begin
                if (dec_s) begin
                    shreg_nx_s[bit_idx_r] = maj_s;
                end else begin
                    shreg_nx_s = shreg_r;
                end
                if (last_s) begin
                    bit_cnt_nx_s = '0;
                    if (bit_idx_r == 3'd7) begin
                        state_nx_s = ST_STOP;
                    end else begin
                        bit_idx_nx_s = bit_idx_r + 3'd1;
                    end
                end else begin
                    bit_cnt_nx_s = bit_cnt_r + CNT_ONE;
                end
            end
            ST_STOP: begin
                if (dec_s) begin
                    bit_cnt_nx_s = '0;
                    if (maj_s) begin
                        // Leave half a bit early so the next START edge is seen on time.
                        byte_done_s = 1'b1;
                        state_nx_s  = ST_IDLE;
                    end else begin
                        frame_err_s = 1'b1;
                        state_nx_s  = ST_WAIT_IDLE;
                    end
                end else begin
                    bit_cnt_nx_s = bit_cnt_r + CNT_ONE;
                end
            end
            ST_WAIT_IDLE: begin
                // A line held low (break) must return high before any new START.
                if (rx_sync_r) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_WAIT_IDLE;
                end
            end
            default: begin
                state_nx_s   = ST_IDLE;
                bit_cnt_nx_s = '0;
            end
        endcase
    end

    // FSM and bit-timing registers; reset aborts any frame in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            bit_cnt_r <= '0;
            bit_idx_r <= 3'd0;
            shreg_r   <= 8'd0;
            rx_busy_r <= 1'b0;
        end else begin
            state_r   <= state_nx_s;
            bit_cnt_r <= bit_cnt_nx_s;
            bit_idx_r <= bit_idx_nx_s;
            shreg_r   <= shreg_nx_s;
            rx_busy_r <= (state_nx_s != ST_IDLE);
        end
    end

    // Capture the first two of the three majority samples; the third is live at the decision.
    always_ff @(posedge clk) begin
        if (rst) begin
            samp0_r <= 1'b1;
            samp1_r <= 1'b1;
        end else begin
            if (bit_cnt_r == CNT_S0) begin
                samp0_r <= rx_sync_r;
            end
            if (bit_cnt_r == CNT_S1) begin
                samp1_r <= rx_sync_r;
            end
        end
    end

    // Output handshake: load, accept-and-reload, overrun drop, and error pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data_r       <= 8'd0;
            rx_valid_r      <= 1'b0;
            frame_error_r   <= 1'b0;
            overrun_error_r <= 1'b0;
        end else begin
            frame_error_r   <= frame_err_s;
            overrun_error_r <= 1'b0;
            if (byte_done_s) begin
                if (!rx_valid_r) begin
                    rx_data_r  <= shreg_r;
                    rx_valid_r <= 1'b1;
                end else if (rx_ready) begin
                    rx_data_r  <= shreg_r;
                    rx_valid_r <= 1'b1;
                end else begin
                    overrun_error_r <= 1'b1;
                end
            end else if (rx_valid_r && rx_ready) begin
                rx_valid_r <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_byte_receiver.sv
// Self-checking bench for uart_byte_receiver using a shortened bit time.
// Expected bytes are queued when a good frame is driven and popped on each handshake.
module tb_uart_byte_receiver;

    localparam int BT  = 64;
    localparam int MID = BT / 2;
    localparam int LAT = 9 * BT + MID + 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       uart_rx = 1'b1;
    logic       rx_ready = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_error;
    logic       overrun_error;
    logic       rx_busy;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int fe_cnt = 0;
    int ovr_cnt = 0;
    int acc_cnt = 0;
    int busy_rise_cnt = 0;
    int start_cyc = 0;
    int valid_rise_cyc = -1;
    int busy_fall_cyc = -1;
    logic prev_valid = 1'b0;
    logic prev_busy = 1'b0;
    logic [7:0] exp_q[$];

    uart_byte_receiver #(
        .CLK_FREQ_HZ     (125_000_000),
        .BAUD_RATE       (115200),
        .BIT_TIME_CYCLES (BT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .uart_rx       (uart_rx),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .frame_error   (frame_error),
        .overrun_error (overrun_error),
        .rx_busy       (rx_busy)
    );

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance n clocks and land 2 time units after the edge.
    task automatic tick(input int n);
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #2;
        end
    endtask

    // Drive one 8N1 frame LSB first; the line is left at the STOP value.
    task automatic send_byte(input logic [7:0] b, input logic stop_val, input int period);
        uart_rx = 1'b0;
        start_cyc = cyc;
        tick(period);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            tick(period);
        end
        uart_rx = stop_val;
        tick(period);
    endtask

    task automatic wait_quiet(input string tag, input int limit);
        int n;
        n = 0;
        while ((rx_busy || rx_valid) && n < limit) begin
            tick(1);
            n++;
        end
        check_eq(tag, 32'(n < limit), 32'd1);
    endtask

    task automatic wait_valid(input string tag, input int limit);
        int n;
        n = 0;
        while (!rx_valid && n < limit) begin
            tick(1);
            n++;
        end
        check_eq(tag, 32'(n < limit), 32'd1);
    endtask

    // Output monitor: scoreboard pops on handshake, counts pulses and edges.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            prev_valid = 1'b0;
            prev_busy = 1'b0;
        end else begin
            if (rx_valid && !prev_valid) valid_rise_cyc = cyc;
            if (!rx_busy && prev_busy) busy_fall_cyc = cyc;
            if (rx_busy && !prev_busy) busy_rise_cnt++;
            if (frame_error) fe_cnt++;
            if (overrun_error) ovr_cnt++;
            if (rx_valid && rx_ready) begin
                check_eq("rx_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    check_eq("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
                    acc_cnt++;
                end
            end
            prev_valid = rx_valid;
            prev_busy = rx_busy;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] bytes5 [5];
        int gaps [2];
        int periods [2];
        int acc0;
        int br0;
        int lat;
        bytes5 = '{8'h5A, 8'hA1, 8'h12, 8'h34, 8'hBC};
        gaps = '{100, 0};
        periods = '{62, 66};

        // Reset state
        tick(5);
        rst = 1'b0;
        tick(2);
        check_eq("rst_valid", 32'(rx_valid), 32'd0);
        check_eq("rst_data", 32'(rx_data), 32'd0);
        check_eq("rst_ferr", 32'(frame_error), 32'd0);
        check_eq("rst_ovr", 32'(overrun_error), 32'd0);
        check_eq("rst_busy", 32'(rx_busy), 32'd0);

        // Test 1: single byte, latency and busy release near mid-STOP
        exp_q.push_back(8'hA5);
        send_byte(8'hA5, 1'b1, BT);
        wait_quiet("t1_timeout", 4 * BT);
        lat = valid_rise_cyc - start_cyc;
        check_eq("t1_latency", 32'(lat >= LAT - 1 && lat <= LAT + 1), 32'd1);
        lat = busy_fall_cyc - start_cyc;
        check_eq("t1_busy_fall", 32'(lat >= LAT - 2 && lat <= LAT + 2), 32'd1);
        check_eq("t1_count", 32'(acc_cnt), 32'd1);
        check_eq("t1_ferr", 32'(fe_cnt), 32'd0);
        check_eq("t1_ovr", 32'(ovr_cnt), 32'd0);

        // Test 2: five bytes with 100-cycle gaps, then back to back
        for (int g = 0; g < 2; g++) begin
            acc0 = acc_cnt;
            tick(10);
            for (int i = 0; i < 5; i++) begin
                exp_q.push_back(bytes5[i]);
                send_byte(bytes5[i], 1'b1, BT);
                tick(gaps[g]);
            end
            wait_quiet("t2_timeout", 4 * BT);
            check_eq("t2_count", 32'(acc_cnt - acc0), 32'd5);
            check_eq("t2_ferr", 32'(fe_cnt), 32'd0);
            check_eq("t2_ovr", 32'(ovr_cnt), 32'd0);
        end

        // Test 3: short low glitch is rejected
        tick(10);
        acc0 = acc_cnt;
        br0 = busy_rise_cnt;
        uart_rx = 1'b0;
        tick(MID / 2);
        uart_rx = 1'b1;
        wait_quiet("t3_timeout", 2 * BT);
        tick(BT);
        check_eq("t3_busy_seen", 32'(busy_rise_cnt - br0), 32'd1);
        check_eq("t3_busy_idle", 32'(rx_busy), 32'd0);
        check_eq("t3_no_byte", 32'(acc_cnt - acc0), 32'd0);
        check_eq("t3_ferr", 32'(fe_cnt), 32'd0);

        // Test 4: bad STOP, line held low, then a good frame
        acc0 = acc_cnt;
        send_byte(8'h3C, 1'b0, BT);
        tick(5 * BT);
        check_eq("t4_wait_busy", 32'(rx_busy), 32'd1);
        check_eq("t4_ferr", 32'(fe_cnt), 32'd1);
        uart_rx = 1'b1;
        tick(2 * BT);
        check_eq("t4_idle", 32'(rx_busy), 32'd0);
        exp_q.push_back(8'h81);
        send_byte(8'h81, 1'b1, BT);
        wait_quiet("t4_timeout", 4 * BT);
        check_eq("t4_count", 32'(acc_cnt - acc0), 32'd1);
        check_eq("t4_ferr_once", 32'(fe_cnt), 32'd1);

        // Test 5: consumer stalled, second byte overruns
        tick(10);
        rx_ready = 1'b0;
        exp_q.push_back(8'h11);
        send_byte(8'h11, 1'b1, BT);
        send_byte(8'h22, 1'b1, BT);
        tick(BT);
        check_eq("t5_ovr", 32'(ovr_cnt), 32'd1);
        check_eq("t5_valid_held", 32'(rx_valid), 32'd1);
        check_eq("t5_data_kept", 32'(rx_data), 32'h11);
        rx_ready = 1'b1;
        tick(1);
        check_eq("t5_valid_drop", 32'(rx_valid), 32'd0);
        check_eq("t5_drained", 32'(exp_q.size()), 32'd0);

        // Test 6: reset during bit 4 of 0xF0 clears a pending byte too
        tick(10);
        rx_ready = 1'b0;
        exp_q.push_back(8'h5A);
        send_byte(8'h5A, 1'b1, BT);
        wait_valid("t6_pending_timeout", 4 * BT);
        check_eq("t6_pending", 32'(rx_data), 32'h5A);
        acc0 = acc_cnt;
        fork
            send_byte(8'hF0, 1'b1, BT);
            begin
                tick(5 * BT + MID);
                rst = 1'b1;
                tick(1);
                rst = 1'b0;
                exp_q.delete();
                check_eq("t6_rst_valid", 32'(rx_valid), 32'd0);
                check_eq("t6_rst_data", 32'(rx_data), 32'd0);
                check_eq("t6_rst_busy", 32'(rx_busy), 32'd0);
            end
        join
        rx_ready = 1'b1;
        tick(5);
        exp_q.push_back(8'h0F);
        send_byte(8'h0F, 1'b1, BT);
        wait_quiet("t6_timeout", 4 * BT);
        check_eq("t6_count", 32'(acc_cnt - acc0), 32'd1);
        check_eq("t6_ferr", 32'(fe_cnt), 32'd1);
        check_eq("t6_ovr", 32'(ovr_cnt), 32'd1);

        // Baud tolerance: transmitter at 1.03x and 0.97x nominal
        for (int p = 0; p < 2; p++) begin
            acc0 = acc_cnt;
            tick(10);
            exp_q.push_back(8'hA5);
            send_byte(8'hA5, 1'b1, periods[p]);
            wait_quiet("baud_timeout", 4 * BT);
            check_eq("baud_count", 32'(acc_cnt - acc0), 32'd1);
        end

        tick(5);
        check_eq("final_drained", 32'(exp_q.size()), 32'd0);
        check_eq("final_ferr", 32'(fe_cnt), 32'd1);
        check_eq("final_ovr", 32'(ovr_cnt), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
